// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants and types for the immediate-generator pipe.
//   - RV32I/RV64I major opcodes (OPC_*)
//   - imm_fmt_t, the 3-bit format code driven on out_fmt
//   - skid_state_t, occupancy of the output register + skid entry
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_OP32    = 7'h3B;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;

    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I      = 3'd1,
        FMT_ISHAMT = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_U      = 3'd5,
        FMT_J      = 3'd6,
        FMT_CSRZ   = 3'd7
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: purely combinational immediate decode.
// Ports:
//   i_inst    [31:0]     instruction word
//   i_pc      [XLEN-1:0] instruction PC
//   o_imm     [XLEN-1:0] extended immediate (0 when illegal)
//   o_fmt     [2:0]      format code (imm_fmt_t)
//   o_target  [XLEN-1:0] pc+imm for B/J/AUIPC, else 0 (0 when illegal)
//   o_illegal            illegal opcode or shamt encoding
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_target,
    output logic            o_illegal
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_sgn;
    logic [XLEN-1:0] w_imm;
    imm_fmt_t        w_fmt;
    logic            w_ill;
    logic            w_tgt_en;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_sgn = {XLEN{i_inst[31]}};

    // Sign-extended forms start from all-sign-bits and overwrite the low
    // field, which works for both XLEN values without zero replications.
    always_comb begin
        w_imm    = '0;
        w_fmt    = FMT_R;
        w_ill    = 1'b0;
        w_tgt_en = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                w_fmt        = FMT_I;
                w_imm        = w_sgn;
                w_imm[11:0]  = i_inst[31:20];
            end
            OPC_OPIMM: begin
                // funct3 001 (sll) / 101 (srl/sra) carry a shamt
                if (w_f3[1:0] == 2'b01) begin
                    w_fmt = FMT_ISHAMT;
                    if (XLEN == 64) begin
                        w_imm[5:0] = i_inst[25:20];
                    end else begin
                        w_imm[4:0] = i_inst[24:20];
                        w_ill      = i_inst[25];
                    end
                end else begin
                    w_fmt       = FMT_I;
                    w_imm       = w_sgn;
                    w_imm[11:0] = i_inst[31:20];
                end
            end
            OPC_OPIMM32: begin
                if (XLEN != 64) begin
                    w_ill = 1'b1;
                end else if (w_f3[1:0] == 2'b01) begin
                    // word shifts: 5-bit shamt regardless of XLEN
                    w_fmt      = FMT_ISHAMT;
                    w_imm[4:0] = i_inst[24:20];
                    w_ill      = i_inst[25];
                end else begin
                    w_fmt       = FMT_I;
                    w_imm       = w_sgn;
                    w_imm[11:0] = i_inst[31:20];
                end
            end
            OPC_AUIPC, OPC_LUI: begin
                w_fmt        = FMT_U;
                w_imm        = w_sgn;
                w_imm[31:0]  = {i_inst[31:12], 12'h000};
                w_tgt_en     = (w_opc == OPC_AUIPC);
            end
            OPC_STORE: begin
                w_fmt       = FMT_S;
                w_imm       = w_sgn;
                w_imm[11:0] = {i_inst[31:25], i_inst[11:7]};
            end
            OPC_BRANCH: begin
                w_fmt       = FMT_B;
                w_imm       = w_sgn;
                w_imm[12:0] = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                w_tgt_en    = 1'b1;
            end
            OPC_JAL: begin
                w_fmt       = FMT_J;
                w_imm       = w_sgn;
                w_imm[20:0] = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                w_tgt_en    = 1'b1;
            end
            OPC_OP: begin
                w_fmt = FMT_R;
            end
            OPC_OP32: begin
                w_ill = (XLEN != 64);
            end
            OPC_SYSTEM: begin
                // only the immediate CSR forms carry a zimm
                if (w_f3[2]) begin
                    w_fmt      = FMT_CSRZ;
                    w_imm[4:0] = i_inst[19:15];
                end
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    assign o_imm     = w_ill ? '0 : w_imm;
    assign o_fmt     = w_fmt;
    assign o_illegal = w_ill;
    // wraps modulo 2^XLEN
    assign o_target  = (w_tgt_en && !w_ill) ? (i_pc + w_imm) : '0;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: 1-cycle immediate generator with a 2-entry skid buffer.
// Optional macro: IMM_GEN_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst (sync, active-high), flush (sync kill)
//   in_valid/in_ready/in_inst/in_pc/in_tag   upstream handshake
//   out_valid/out_ready                      downstream handshake
//   out_imm/out_fmt/out_target/out_tag/out_illegal  decoded result
//   perf_accepted/perf_illegal/perf_stall    (IMM_GEN_PERF_EN only)
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [31:0]      perf_accepted,
    output logic [31:0]      perf_illegal,
    output logic [31:0]      perf_stall
`endif
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } ent_t;

    skid_state_t r_state, w_state_nxt;
    ent_t        r_main, r_skid, w_main_nxt, w_skid_nxt, w_new;
    logic        w_in_xfer, w_out_xfer;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_inst    (in_inst),
        .i_pc      (in_pc),
        .o_imm     (w_new.imm),
        .o_fmt     (w_new.fmt),
        .o_target  (w_new.target),
        .o_illegal (w_new.illegal)
    );
    assign w_new.tag = in_tag;

    // Depends only on state and the rst/flush inputs, never on out_ready.
    assign in_ready   = (r_state != ST_TWO) && !rst && !flush;
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_new;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_nxt = w_new;
                    end else if (w_in_xfer) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = w_new;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_out_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    assign out_imm     = r_main.imm;
    assign out_fmt     = r_main.fmt;
    assign out_target  = r_main.target;
    assign out_tag     = r_main.tag;
    assign out_illegal = r_main.illegal;

`ifdef IMM_GEN_PERF_EN
    logic [31:0] r_perf_acc, r_perf_ill, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_acc   <= '0;
            r_perf_ill   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_in_xfer && r_perf_acc != 32'hFFFF_FFFF)
                r_perf_acc <= r_perf_acc + 32'd1;
            if (w_in_xfer && w_new.illegal && r_perf_ill != 32'hFFFF_FFFF)
                r_perf_ill <= r_perf_ill + 32'd1;
            if (out_valid && !out_ready && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_accepted = r_perf_acc;
    assign perf_illegal  = r_perf_ill;
    assign perf_stall    = r_perf_stall;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [3:0]  in_tag;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic [3:0]  tag32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;
    logic [3:0]  tag64;

`ifdef IMM_GEN_PERF_EN
    logic [31:0] pa32, pi32, ps32, pa64, pi64, ps64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
        .in_pc(in_pc[31:0]), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_target(tgt32), .out_tag(tag32),
        .out_illegal(ill32)
`ifdef IMM_GEN_PERF_EN
        , .perf_accepted(pa32), .perf_illegal(pi32), .perf_stall(ps32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
        .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_target(tgt64), .out_tag(tag64),
        .out_illegal(ill64)
`ifdef IMM_GEN_PERF_EN
        , .perf_accepted(pa64), .perf_illegal(pi64), .perf_stall(ps64)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc, input logic [3:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_tag   = tag;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_tag = '0;
        tick(); tick();
        chk("rst_in_ready32", {63'd0, rdy32}, 64'd0);
        chk("rst_in_ready64", {63'd0, rdy64}, 64'd0);
        chk("rst_out_valid",  {62'd0, vld32, vld64}, 64'd0);
        chk("rst_imm64",      imm64, 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("idle_in_ready", {62'd0, rdy32, rdy64}, 64'd3);

        // addi -1, then csrrwi zimm=31, streamed back to back
        send(32'hFFF00093, 64'h0, 4'd1);
        tick();
        chk("addi_valid", {63'd0, vld32}, 64'd1);
        chk("addi_imm32", {32'd0, imm32}, 64'hFFFF_FFFF);
        chk("addi_fmt",   {61'd0, fmt32}, 64'd1);
        chk("addi_tag",   {60'd0, tag32}, 64'd1);
        chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h340FD073, 64'h0, 4'd2);
        tick();
        chk("csrz_imm", {32'd0, imm32}, 64'h1F);
        chk("csrz_fmt", {61'd0, fmt32}, 64'd7);
        chk("csrz_tag", {60'd0, tag32}, 64'd2);
        // csrrw (funct3[2]=0) -> R, imm 0
        send(32'h34001073, 64'h0, 4'd3);
        tick();
        chk("csrrw_fmt", {61'd0, fmt32}, 64'd0);
        chk("csrrw_imm", {32'd0, imm32}, 64'd0);
        // jal x0,-4 at 0x100
        send(32'hFFDFF06F, 64'h100, 4'd4);
        tick();
        chk("jal_imm",    {32'd0, imm32}, 64'hFFFF_FFFC);
        chk("jal_target", {32'd0, tgt32}, 64'hFC);
        chk("jal_fmt",    {61'd0, fmt32}, 64'd6);
        chk("jal_tgt64",  tgt64, 64'hFC);
        // jal -4 at pc 0 wraps
        send(32'hFFDFF06F, 64'h0, 4'd5);
        tick();
        chk("jal_wrap32", {32'd0, tgt32}, 64'hFFFF_FFFC);
        chk("jal_wrap64", tgt64, 64'hFFFF_FFFF_FFFF_FFFC);
        // auipc 0x1 at 0x200
        send(32'h00001017, 64'h200, 4'd6);
        tick();
        chk("auipc_imm", {32'd0, imm32}, 64'h1000);
        chk("auipc_tgt", {32'd0, tgt32}, 64'h1200);
        chk("auipc_fmt", {61'd0, fmt32}, 64'd5);
        // sw x1,-1(x0)
        send(32'hFE102FA3, 64'h0, 4'd7);
        tick();
        chk("sw_imm", {32'd0, imm32}, 64'hFFFF_FFFF);
        chk("sw_fmt", {61'd0, fmt32}, 64'd3);
        chk("sw_tgt", {32'd0, tgt32}, 64'd0);
        // lui 0x80000
        send(32'h800000B7, 64'h0, 4'd8);
        tick();
        chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_imm32", {32'd0, imm32}, 64'h8000_0000);
        chk("lui_fmt",   {61'd0, fmt64}, 64'd5);
        // slli 63: legal on RV64, illegal on RV32
        send(32'h03F09093, 64'h0, 4'd9);
        tick();
        chk("slli63_imm64", imm64, 64'h3F);
        chk("slli63_ill64", {63'd0, ill64}, 64'd0);
        chk("slli63_fmt64", {61'd0, fmt64}, 64'd2);
        chk("slli63_ill32", {63'd0, ill32}, 64'd1);
        chk("slli63_imm32", {32'd0, imm32}, 64'd0);
        // slli 32
        send(32'h02009093, 64'h0, 4'd10);
        tick();
        chk("slli32_ill32", {63'd0, ill32}, 64'd1);
        chk("slli32_imm32", {32'd0, imm32}, 64'd0);
        chk("slli32_imm64", imm64, 64'h20);
        // slliw with inst[25]=1: illegal on RV64, illegal opcode on RV32
        send(32'h0200909B, 64'h0, 4'd11);
        tick();
        chk("slliw_ill64", {63'd0, ill64}, 64'd1);
        chk("slliw_ill32", {63'd0, ill32}, 64'd1);
        // addw: R on RV64, illegal on RV32
        send(32'h0000003B, 64'h0, 4'd12);
        tick();
        chk("addw_ill64", {63'd0, ill64}, 64'd0);
        chk("addw_ill32", {63'd0, ill32}, 64'd1);
        // opcode 0x0B
        send(32'h0000000B, 64'h40, 4'd13);
        tick();
        chk("opc0b_ill", {62'd0, ill32, ill64}, 64'd3);
        chk("opc0b_fmt", {61'd0, fmt32}, 64'd0);
        chk("opc0b_imm", {32'd0, imm32}, 64'd0);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", {62'd0, vld32, vld64}, 64'd0);

        // back-pressure: tags 1,2 fill main+skid, tag 3 waits upstream
        out_ready = 1'b0;
        send(32'hFFF00093, 64'h0, 4'd1);
        tick();
        chk("bp_ready_after1", {63'd0, rdy32}, 64'd1);
        send(32'hFFF00093, 64'h0, 4'd2);
        tick();
        chk("bp_ready_after2", {62'd0, rdy32, rdy64}, 64'd0);
        send(32'hFFF00093, 64'h0, 4'd3);
        tick();
        chk("bp_hold_ready", {63'd0, rdy32}, 64'd0);
        chk("bp_hold_tag",   {60'd0, tag32}, 64'd1);
        chk("bp_hold_valid", {63'd0, vld32}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_out2_valid", {63'd0, vld32}, 64'd1);
        chk("bp_out2_tag",   {60'd0, tag32}, 64'd2);
        chk("bp_out2_ready", {63'd0, rdy32}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out3_valid", {63'd0, vld32}, 64'd1);
        chk("bp_out3_tag",   {60'd0, tag64}, 64'd3);
        tick();
        chk("bp_done", {63'd0, vld32}, 64'd0);

        // flush with both entries full and in_valid held
        out_ready = 1'b0;
        send(32'hFFF00093, 64'h0, 4'd4);
        tick();
        send(32'hFFF00093, 64'h0, 4'd5);
        tick();
        send(32'hFFF00093, 64'h0, 4'd6);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {62'd0, rdy32, rdy64}, 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {62'd0, vld32, vld64}, 64'd0);
        tick();
        chk("flush_nothing_taken", {62'd0, vld32, vld64}, 64'd0);

        // reset mid-stream
        out_ready = 1'b1;
        send(32'hFFDFF06F, 64'h100, 4'd7);
        tick();
        chk("pre_rst_valid", {63'd0, vld32}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_hi_ready", {62'd0, rdy32, rdy64}, 64'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid", {62'd0, vld32, vld64}, 64'd0);
        chk("rst_imm",   {32'd0, imm32}, 64'd0);
        chk("rst_tgt",   {32'd0, tgt32}, 64'd0);
        chk("rst_misc",  {56'd0, fmt32, tag32, ill32}, 64'd0);
        chk("rst_tgt64", tgt64, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
